// File: rtl/alu_ctrl_pkg.sv
// Shared ALU-control encodings: ALUOp, funct and ALU select codes, sequencer state type.
// Used by alu_funct_decode, alu_control_seq and the forwarding unit.
package alu_ctrl_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;
    localparam logic [2:0] ALUOP_LUI   = 3'b110;
    localparam logic [2:0] ALUOP_ILL   = 3'b111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_OR   = 4'b0010;
    localparam logic [3:0] SEL_AND  = 4'b0011;
    localparam logic [3:0] SEL_SLT  = 4'b0100;
    localparam logic [3:0] SEL_XOR  = 4'b0101;
    localparam logic [3:0] SEL_NOR  = 4'b0110;
    localparam logic [3:0] SEL_SLL  = 4'b0111;
    localparam logic [3:0] SEL_SRL  = 4'b1000;
    localparam logic [3:0] SEL_SRA  = 4'b1001;
    localparam logic [3:0] SEL_MULT = 4'b1010;
    localparam logic [3:0] SEL_DIV  = 4'b1011;
    localparam logic [3:0] SEL_LUI  = 4'b1100;
    localparam logic [3:0] SEL_NOP  = 4'b1111;

    typedef enum logic {IDLE, MD_RUN} state_t;

    function automatic logic is_muldiv(input logic [3:0] sel);
        return (sel == SEL_MULT) || (sel == SEL_DIV);
    endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational {ALUOp, funct} -> ALU select decode with illegal flag and MULT/DIV tags.
// Undefined encodings map to SEL_NOP with illegal set.
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W   = 3,
    parameter int FUNC_W = 6,
    parameter int SEL_W  = 4
) (
    input  logic [OP_W-1:0]   alu_op,
    input  logic [FUNC_W-1:0] funct,
    output logic [SEL_W-1:0]  sel,
    output logic              illegal,
    output logic              is_mul,
    output logic              is_div
);

    logic [3:0] sel4;

    always_comb begin
        sel4    = SEL_NOP;
        illegal = 1'b0;
        case (alu_op)
            OP_W'(ALUOP_ADD): sel4 = SEL_ADD;
            OP_W'(ALUOP_SUB): sel4 = SEL_SUB;
            OP_W'(ALUOP_AND): sel4 = SEL_AND;
            OP_W'(ALUOP_OR):  sel4 = SEL_OR;
            OP_W'(ALUOP_SLT): sel4 = SEL_SLT;
            OP_W'(ALUOP_LUI): sel4 = SEL_LUI;
            OP_W'(ALUOP_RTYPE): begin
                case (funct)
                    FUNC_W'(FN_ADD):  sel4 = SEL_ADD;
                    FUNC_W'(FN_SUB):  sel4 = SEL_SUB;
                    FUNC_W'(FN_OR):   sel4 = SEL_OR;
                    FUNC_W'(FN_AND):  sel4 = SEL_AND;
                    FUNC_W'(FN_SLT):  sel4 = SEL_SLT;
                    FUNC_W'(FN_XOR):  sel4 = SEL_XOR;
                    FUNC_W'(FN_NOR):  sel4 = SEL_NOR;
                    FUNC_W'(FN_SLL):  sel4 = SEL_SLL;
                    FUNC_W'(FN_SRL):  sel4 = SEL_SRL;
                    FUNC_W'(FN_SRA):  sel4 = SEL_SRA;
                    FUNC_W'(FN_MULT): sel4 = SEL_MULT;
                    FUNC_W'(FN_DIV):  sel4 = SEL_DIV;
                    default:          illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign sel    = SEL_W'(sel4);
    assign is_mul = (sel4 == SEL_MULT);
    assign is_div = (sel4 == SEL_DIV);

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU-control stage between ID and EX: valid/ready handshake, flush, MULT/DIV stall sequencer.
// Optional ALUCTL_STATS_EN adds saturating accept/stall counters (stat_ops, stat_stall).
//
// state  | meaning
// IDLE   | issuing single-cycle ops; output register follows handshake
// MD_RUN | MULT/DIV in flight, issue stalled, counter runs down to 0
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W       = 3,
    parameter int FUNC_W     = 6,
    parameter int SEL_W      = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   alu_op,
    input  logic [FUNC_W-1:0] funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  alu_sel,
    output logic              illegal,
    output logic              md_busy,
    output logic              md_done
`ifdef ALUCTL_STATS_EN
    ,
    output logic [31:0]       stat_ops,
    output logic [31:0]       stat_stall
`endif
);

    if (OP_W < 1 || FUNC_W < 1 || SEL_W < 4 || MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_param_check
        $error("alu_control_seq: illegal parameter value");
    end

    localparam int MAXN  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXN) + 1;
    localparam logic [CNT_W-1:0] CNT_MUL0 = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_DIV0 = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               md_div, md_div_nx;
    logic               out_valid_nx, illegal_nx, md_done_nx;
    logic [SEL_W-1:0]   alu_sel_nx;

    logic [SEL_W-1:0]   dec_sel;
    logic               dec_illegal, dec_is_mul, dec_is_div;
    logic               accept, md_path;

    alu_funct_decode #(
        .OP_W   (OP_W),
        .FUNC_W (FUNC_W),
        .SEL_W  (SEL_W)
    ) u_decode (
        .alu_op  (alu_op),
        .funct   (funct),
        .sel     (dec_sel),
        .illegal (dec_illegal),
        .is_mul  (dec_is_mul),
        .is_div  (dec_is_div)
    );

    assign md_busy  = (state == MD_RUN);
    assign in_ready = !flush && !md_busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    // A one-cycle MULT/DIV latency degenerates to an ordinary single-cycle issue.
    assign md_path  = is_muldiv(dec_sel[3:0]) &&
                      (dec_is_mul ? (MUL_CYCLES > 1) : (DIV_CYCLES > 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            md_div    <= 1'b0;
            out_valid <= 1'b0;
            alu_sel   <= SEL_W'(SEL_NOP);
            illegal   <= 1'b0;
            md_done   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            md_div    <= md_div_nx;
            out_valid <= out_valid_nx;
            alu_sel   <= alu_sel_nx;
            illegal   <= illegal_nx;
            md_done   <= md_done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        md_div_nx    = md_div;
        out_valid_nx = out_valid;
        alu_sel_nx   = alu_sel;
        illegal_nx   = illegal;
        md_done_nx   = 1'b0;
        if (flush) begin
            state_nx     = IDLE;
            cnt_nx       = '0;
            out_valid_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready)
                        out_valid_nx = 1'b0;
                    if (accept) begin
                        if (md_path) begin
                            state_nx     = MD_RUN;
                            cnt_nx       = dec_is_div ? CNT_DIV0 : CNT_MUL0;
                            md_div_nx    = dec_is_div;
                            out_valid_nx = 1'b0;
                        end else begin
                            out_valid_nx = 1'b1;
                            alu_sel_nx   = dec_sel;
                            illegal_nx   = dec_illegal;
                        end
                    end
                end
                MD_RUN: begin
                    if (cnt == '0) begin
                        state_nx     = IDLE;
                        out_valid_nx = 1'b1;
                        alu_sel_nx   = md_div ? SEL_W'(SEL_DIV) : SEL_W'(SEL_MULT);
                        illegal_nx   = 1'b0;
                        md_done_nx   = 1'b1;
                    end else begin
                        cnt_nx = cnt - CNT_W'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

`ifdef ALUCTL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (accept && (stat_ops != 32'hFFFF_FFFF))
                stat_ops <= stat_ops + 32'd1;
            if (in_valid && !in_ready && (stat_stall != 32'hFFFF_FFFF))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed sweeps plus random traffic against a latency-based model.
module tb_alu_control_seq;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] alu_op = '0;
    logic [5:0] funct = '0;
    logic       in_ready, out_valid, illegal, md_busy, md_done;
    logic [3:0] alu_sel;
`ifdef ALUCTL_STATS_EN
    logic [31:0] stat_ops, stat_stall;
`endif

    alu_control_seq #(
        .OP_W(3), .FUNC_W(6), .SEL_W(4), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_sel   (alu_sel),
        .illegal   (illegal),
        .md_busy   (md_busy),
        .md_done   (md_done)
`ifdef ALUCTL_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // funct code whose position is its ALU select value
    int fn_tab[12] = '{32, 34, 37, 36, 42, 38, 39, 0, 2, 3, 24, 26};
    // ALUOp -> select; -1 means decode by funct, 15 means illegal
    int op_tab[8]  = '{0, 1, -1, 3, 2, 4, 12, 15};

    int n_checks = 0;
    int n_fail   = 0;

    bit exp_valid, exp_ill, exp_done, last_accept;
    int exp_sel, pend_sel, busy_left;
    int exp_ops = 0, exp_stall = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void ref_decode(input int op, input int fn, output int sel, output bit ill);
        sel = 15;
        ill = 1'b1;
        if (op != 2) begin
            if (op_tab[op] != 15) begin
                sel = op_tab[op];
                ill = 1'b0;
            end
        end else begin
            for (int i = 0; i < 12; i++)
                if (fn_tab[i] == fn) begin
                    sel = i;
                    ill = 1'b0;
                end
        end
    endfunction

    task automatic model_reset();
        exp_valid = 0; exp_ill = 0; exp_done = 0; exp_sel = 15; busy_left = 0; pend_sel = 0;
        last_accept = 0;
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".out_valid"}, out_valid, exp_valid);
        if (exp_valid) begin
            check({ctx, ".alu_sel"}, alu_sel, exp_sel);
            check({ctx, ".illegal"}, illegal, exp_ill);
        end
        check({ctx, ".md_busy"}, md_busy, busy_left > 0);
        check({ctx, ".md_done"}, md_done, exp_done);
    endtask

    task automatic cycle(input bit f, input bit iv, input int op, input int fn, input bit ordy);
        bit rdy;
        int s, lat;
        bit ill;
        @(negedge clk);
        check_outputs("cyc");
        flush = f; in_valid = iv; alu_op = op[2:0]; funct = fn[5:0]; out_ready = ordy;
        rdy = !f && (busy_left == 0) && (!exp_valid || ordy);
        #1;
        check("in_ready", in_ready, rdy);
        @(posedge clk);
        last_accept = iv && rdy;
        exp_done = 0;
        if (last_accept) exp_ops++;
        if (iv && !rdy) exp_stall++;
        if (f) begin
            exp_valid = 0;
            busy_left = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                exp_valid = 1; exp_sel = pend_sel; exp_ill = 0; exp_done = 1;
            end
        end else begin
            if (exp_valid && ordy) exp_valid = 0;
            if (last_accept) begin
                ref_decode(op, fn, s, ill);
                lat = (s == 10) ? MUL_N : (s == 11) ? DIV_N : 1;
                if (lat > 1) begin
                    busy_left = lat - 1;
                    pend_sel = s;
                end else begin
                    exp_valid = 1; exp_sel = s; exp_ill = ill;
                end
            end
        end
    endtask

    task automatic issue(input int op, input int fn);
        bit done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            cycle(0, 1, op, fn, 1);
            done = last_accept;
        end
        check("issue_accept", done, 1);
    endtask

    task automatic check_reset_vals(input string ctx);
        check({ctx, ".out_valid"}, out_valid, 0);
        check({ctx, ".alu_sel"}, alu_sel, 4'hF);
        check({ctx, ".illegal"}, illegal, 0);
        check({ctx, ".md_busy"}, md_busy, 0);
        check({ctx, ".md_done"}, md_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, fn;
        model_reset();
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // every legal funct, every non-R ALUOp, the two illegal cases
        for (int i = 0; i < 12; i++) issue(2, fn_tab[i]);
        for (int o = 0; o < 8; o++) if (o != 2) issue(o, 0);
        issue(2, 63);

        // backpressure: first op accepted, next three stalled, then consume and issue together
        issue(0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 1);
        check("no_bubble_accept", last_accept, 1);
        cycle(0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 7);
            fn = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 11)] : int'($urandom_range(0, 63));
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, op, fn,
                  $urandom_range(0, 3) != 0);
        end

        // flush five cycles into a DIV
        issue(2, 26);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // asynchronous reset in the middle of a DIV
        issue(2, 26);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        model_reset();
        in_valid = 1'b0;
        flush = 1'b0;
`ifdef ALUCTL_STATS_EN
        check("stat_ops_rst", stat_ops, 0);
        check("stat_stall_rst", stat_stall, 0);
        exp_ops = 0;
        exp_stall = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 1), $urandom_range(0, 7),
                  fn_tab[$urandom_range(0, 11)], $urandom_range(0, 1));
        cycle(0, 0, 0, 0, 1);
`ifdef ALUCTL_STATS_EN
        @(negedge clk);
        check("stat_ops", stat_ops, exp_ops);
        check("stat_stall", stat_stall, exp_stall);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
